// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: state codes, nibble width,
// and the sizing helper for the nibble counter.
package adder_seq_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Bits needed to hold 0..nibbles, i.e. ceil(log2(nibbles+1)), never less than 1.
    function automatic int nib_cnt_w(input int nibbles);
        int w;
        w = 1;
        while ((1 << w) < (nibbles + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder4.sv
// 4-bit ripple-carry adder with carry-in; purely combinational, no flow control.
module adder4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] S,
    output logic       C4
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = CIN;
        for (int i = 0; i < 4; i++) begin
            S[i]     = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        C4 = c[4];
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial W-bit adder reusing one adder4; result after NIBBLES RUN cycles, held in
// DONE until out_ready. Optional subtract via macro ADDSEQ_SUB_EN (A + ~B + 1).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         busy
);

    localparam int            CW   = nib_cnt_w(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            carry_out_q, carry_out_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NIB_W-1:0] add_a, add_b, add_s;
    logic             add_c;
    logic [W-1:0]     sum_next;

`ifdef ADDSEQ_SUB_EN
    logic sub_q, sub_d;
    assign add_b = b_sh_q[NIB_W-1:0] ^ {NIB_W{sub_q}};
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign add_b = b_sh_q[NIB_W-1:0];
`endif

    assign add_a = a_sh_q[NIB_W-1:0];

    adder4 u_adder4 (
        .A   (add_a),
        .B   (add_b),
        .CIN (carry_q),
        .S   (add_s),
        .C4  (add_c)
    );

    // New nibble enters at the MS end so the LS nibble ends up at bit 0 after the last step.
    generate
        if (NIBBLES == 1) begin : g_one_nib
            assign sum_next = add_s;
        end else begin : g_multi_nib
            assign sum_next = {add_s, sum_q[W-1:NIB_W]};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        cnt_d       = cnt_q;
`ifdef ADDSEQ_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    cnt_d   = '0;
`ifdef ADDSEQ_SUB_EN
                    sub_d   = op_sub;
                    carry_d = op_sub;
`else
                    carry_d = 1'b0;
`endif
                end
            end
            RUN: begin
                sum_d   = sum_next;
                carry_d = add_c;
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    carry_out_d = add_c;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            cnt_q       <= '0;
`ifdef ADDSEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            cnt_q       <= cnt_d;
`ifdef ADDSEQ_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomised scoreboard bench for adder_seq_ctrl (NIBBLES=4) plus a directed NIBBLES=1 instance.
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, op_sub, out_valid, out_ready, carry_out, busy;
    logic [W-1:0] op_a, op_b, sum;

    logic       in_valid1, in_ready1, op_sub1, out_valid1, out_ready1, carry_out1, busy1;
    logic [3:0] op_a1, op_b1, sum1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;
    exp_t sbq[$];

    adder_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .busy(busy)
    );

    adder_seq_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .carry_out(carry_out1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t       e;
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b};
`ifdef ADDSEQ_SUB_EN
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
        e.s   = r[W-1:0];
        e.c   = r[W];
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // acc is the cycle count right after the accept edge; counting that edge as the first,
    // out_valid must be visible after edge N+1, i.e. N edges later.
    bit   seen = 0;
    bit   prev_hs = 0;
    exp_t me;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen    = 0;
            prev_hs = 0;
        end else begin
            if (prev_hs) chk("ready_after_hs", {in_ready, out_valid}, 2'b10);
            prev_hs = 0;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 0);
                end else begin
                    me = sbq[0];
                    if (!seen) begin
                        chk("latency", cyc - me.acc, N);
                        seen = 1;
                    end
                    chk("sum", sum, me.s);
                    chk("carry_out", carry_out, me.c);
                    chk("ready_busy_in_done", {in_ready, busy}, 2'b00);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        seen    = 0;
                        prev_hs = 1;
                    end
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit push);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'(in_ready), 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (push) begin
            e     = model(a, b, sub);
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        op_sub   = 1'($urandom);
        @(negedge clk);
        chk("busy_after_accept", {busy, in_ready, out_valid}, 3'b100);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_sub     = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        op_a1      = '0;
        op_b1      = '0;
        op_sub1    = 1'b0;
        out_ready1 = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_state", {in_ready, out_valid, busy, carry_out, sum}, {4'b1000, 16'h0});
        chk("reset_state_n1", {in_ready1, out_valid1, busy1, carry_out1, sum1}, {4'b1000, 4'h0});
        rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1);
        wait_drain();

        rdy_mode = 2;
        do_op(16'hBEEF, 16'h1111, 1'b0, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            @(negedge clk);
            chk("hold_flags", {out_valid, in_ready}, 2'b10);
            chk("hold_sum", sum, 16'hD000);
        end
        rdy_mode = 0;
        wait_drain();

        do_op(16'hAAAA, 16'h5555, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midop_reset", {in_ready, out_valid, busy, carry_out, sum}, {4'b1000, 16'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_op(16'h0001, 16'h0002, 1'b0, 1);
        wait_drain();

`ifdef ADDSEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1);
        do_op(16'h0007, 16'h0005, 1'b1, 1);
        wait_drain();
`endif

        rdy_mode = 1;
        repeat (40) do_op(W'($urandom), W'($urandom), 1'($urandom), 1);
        wait_drain();
        rdy_mode = 0;

        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        op_a1     = 4'hF;
        op_b1     = 4'h1;
        @(negedge clk);
        chk("n1_ready", 32'(in_ready1), 1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        op_a1     = 4'h0;
        @(negedge clk);
        chk("n1_run", {busy1, out_valid1}, 2'b10);
        @(negedge clk);
        chk("n1_done", {out_valid1, carry_out1, sum1}, {2'b11, 4'h0});
        @(negedge clk);
        chk("n1_idle", {in_ready1, out_valid1}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
